// File: rtl/ysyx_22050078_pipe_ctrl_pkg.sv
// Shared widths and sequencer state encoding for the pipeline stall/flush controller.
package ysyx_22050078_pipe_ctrl_pkg;

    localparam int unsigned REG_ADDRW = 5;

    typedef enum logic [1:0] {
        PIPE_ST_IDLE = 2'b00,
        PIPE_ST_WAIT = 2'b01,
        PIPE_ST_ERR  = 2'b10
    } pipe_st_e;

endpackage

// File: rtl/ysyx_22050078_pipe_ctrl_hazard.sv
// Load-use detector: ID reads a register that the load currently in EX will write.
module ysyx_22050078_hazard_det
    import ysyx_22050078_pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDRW-1:0] i_rs1_addr,
    input  logic [REG_ADDRW-1:0] i_rs2_addr,
    input  logic                 i_rs1_ren,
    input  logic                 i_rs2_ren,
    input  logic [REG_ADDRW-1:0] i_rd_addr,
    input  logic                 i_lden,
    output logic                 o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_rs1_ren && (i_rs1_addr == i_rd_addr);
    assign w_rs2_hit  = i_rs2_ren && (i_rs2_addr == i_rd_addr);
    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign o_load_use = i_lden && (i_rd_addr != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/ysyx_22050078_pipe_ctrl.sv
// Pipeline stall/flush sequencer with data-memory wait FSM and watchdog.
// Optional performance counters enabled by defining YSYX_PIPE_PERF_EN.
module ysyx_22050078_pipe_ctrl
    import ysyx_22050078_pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 8
`ifdef YSYX_PIPE_PERF_EN
    ,
    parameter int unsigned PERF_CNTW = 32
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [REG_ADDRW-1:0] i_idu_rs1_addr,
    input  logic [REG_ADDRW-1:0] i_idu_rs2_addr,
    input  logic                 i_idu_rs1_ren,
    input  logic                 i_idu_rs2_ren,
    input  logic [REG_ADDRW-1:0] i_exu_rd_addr,
    input  logic                 i_exu_lden,
    input  logic                 i_exu_redirect,
    input  logic                 i_lsu_req,
    input  logic                 i_mem_ready,
    output logic                 o_mem_valid,
    output logic                 o_pc_wen,
    output logic                 o_ifid_wen,
    output logic                 o_idex_wen,
    output logic                 o_exls_wen,
    output logic                 o_lswb_wen,
    output logic                 o_ifid_flush,
    output logic                 o_idex_flush,
    output logic                 o_lswb_flush,
    output logic                 o_mem_err
`ifdef YSYX_PIPE_PERF_EN
    ,
    output logic [PERF_CNTW-1:0] o_perf_memstall,
    output logic [PERF_CNTW-1:0] o_perf_ldstall,
    output logic [PERF_CNTW-1:0] o_perf_flush
`endif
);

    localparam logic [TIMEOUT_W-1:0] WD_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

    pipe_st_e             r_state;
    pipe_st_e             w_state_nxt;
    logic [TIMEOUT_W-1:0] r_wd;
    logic [TIMEOUT_W-1:0] w_wd_nxt;
    logic                 w_mem_stall;
    logic                 w_load_use;
    logic                 w_redirect_act;
    logic                 w_load_use_act;

    ysyx_22050078_hazard_det u_hazard_det (
        .i_rs1_addr (i_idu_rs1_addr),
        .i_rs2_addr (i_idu_rs2_addr),
        .i_rs1_ren  (i_idu_rs1_ren),
        .i_rs2_ren  (i_idu_rs2_ren),
        .i_rd_addr  (i_exu_rd_addr),
        .i_lden     (i_exu_lden),
        .o_load_use (w_load_use)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= PIPE_ST_IDLE;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

    // Memory wait FSM: request handshake, watchdog, stall generation
    always_comb begin
        w_state_nxt = r_state;
        w_wd_nxt    = r_wd;
        w_mem_stall = 1'b0;
        o_mem_valid = 1'b0;
        o_mem_err   = 1'b0;
        unique case (r_state)
            PIPE_ST_IDLE: begin
                o_mem_valid = i_lsu_req;
                w_wd_nxt    = '0;
                if (i_lsu_req && !i_mem_ready) begin
                    w_mem_stall = 1'b1;
                    w_state_nxt = PIPE_ST_WAIT;
                end
            end
            PIPE_ST_WAIT: begin
                o_mem_valid = 1'b1;
                w_mem_stall = !i_mem_ready;
                if (i_mem_ready) begin
                    w_state_nxt = PIPE_ST_IDLE;
                    w_wd_nxt    = '0;
                end else begin
                    w_wd_nxt = r_wd + TIMEOUT_W'(1);
                    if (r_wd == WD_LAST) begin
                        w_state_nxt = PIPE_ST_ERR;
                    end
                end
            end
            PIPE_ST_ERR: begin
                w_mem_stall = 1'b1;
                o_mem_err   = 1'b1;
            end
            default: begin
                w_state_nxt = PIPE_ST_IDLE;
                w_wd_nxt    = '0;
            end
        endcase
    end

    assign w_redirect_act = !w_mem_stall && i_exu_redirect;
    assign w_load_use_act = !w_mem_stall && !i_exu_redirect && w_load_use;

    // Priority mux: memory stall freezes everything, then redirect, then load-use bubble
    always_comb begin
        o_pc_wen     = 1'b1;
        o_ifid_wen   = 1'b1;
        o_idex_wen   = 1'b1;
        o_exls_wen   = 1'b1;
        o_lswb_wen   = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        o_lswb_flush = 1'b0;
        if (w_mem_stall) begin
            o_pc_wen     = 1'b0;
            o_ifid_wen   = 1'b0;
            o_idex_wen   = 1'b0;
            o_exls_wen   = 1'b0;
            // LS/WB takes a bubble so the stalled instruction is not committed twice
            o_lswb_flush = 1'b1;
        end else if (w_redirect_act) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (w_load_use_act) begin
            o_pc_wen     = 1'b0;
            o_ifid_wen   = 1'b0;
            o_idex_flush = 1'b1;
        end
    end

`ifdef YSYX_PIPE_PERF_EN
    logic [PERF_CNTW-1:0] r_perf_memstall;
    logic [PERF_CNTW-1:0] r_perf_ldstall;
    logic [PERF_CNTW-1:0] r_perf_flush;

    // Saturating event counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_memstall <= '0;
            r_perf_ldstall  <= '0;
            r_perf_flush    <= '0;
        end else begin
            if (w_mem_stall && (r_perf_memstall != '1)) begin
                r_perf_memstall <= r_perf_memstall + PERF_CNTW'(1);
            end
            if (w_load_use_act && (r_perf_ldstall != '1)) begin
                r_perf_ldstall <= r_perf_ldstall + PERF_CNTW'(1);
            end
            if (w_redirect_act && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + PERF_CNTW'(1);
            end
        end
    end

    assign o_perf_memstall = r_perf_memstall;
    assign o_perf_ldstall  = r_perf_ldstall;
    assign o_perf_flush    = r_perf_flush;
`endif

endmodule
